// File: rtl/decoder_pkg.sv
// Shared constants and the one-hot decode helper for the decoder_pipe_func slice.
//   SEL_W_MAX        : widest supported select
//   OUT_W_MAX        : widest decoded word (2**SEL_W_MAX)
//   DEC_MASK_DEFAULT : reset minterm mask (minterms 1,3,6,7)
//   onehot_dec()     : sel -> one-hot word, all zeros when en is low
package decoder_pkg;

  localparam int unsigned SEL_W_MAX = 6;
  localparam int unsigned OUT_W_MAX = 1 << SEL_W_MAX;

  localparam logic [OUT_W_MAX-1:0] DEC_MASK_DEFAULT = 64'hCA;

  function automatic logic [OUT_W_MAX-1:0] onehot_dec(input logic [SEL_W_MAX-1:0] sel,
                                                      input logic                 en);
    logic [OUT_W_MAX-1:0] word;
    word = '0;
    if (en) word[sel] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/decoder_nx.sv
// Combinational SEL_W-to-OUT_W decoder with a three-line enable.
// Ports:
//   e1_n, e2_n : enables, active-low
//   e3         : enable, active-high
//   sel        : select code, sel[SEL_W-1] is the MSB
//   y          : decoded word; active-low (inactive = all ones) when ACTIVE_LOW,
//                else active-high (inactive = all zeros)
module decoder_nx
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned OUT_W     = 1 << SEL_W
) (
  input  logic             e1_n,
  input  logic             e2_n,
  input  logic             e3,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y
);

  logic             en;
  logic [OUT_W-1:0] onehot;

  always_comb begin
    en     = e3 & ~e1_n & ~e2_n;
    onehot = OUT_W'(onehot_dec(SEL_W_MAX'(sel), en));
    y      = ACTIVE_LOW ? ~onehot : onehot;
  end

endmodule

// File: rtl/decoder_pipe_func.sv
// Two-stage valid/ready decoder with a runtime-programmable minterm function.
//   Stage 1 captures the decoded word, stage 2 captures y and func = |(onehot & mask_q).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   e1_n, e2_n, e3      : decoder enables
//   in_valid, in_ready  : input handshake (in_ready is combinational from out_ready)
//   sel                 : select code
//   cfg_we, cfg_mask    : mask write; mask_q reads the current mask back
//   out_valid, out_ready: output handshake
//   y, func             : decoded word (polarity per ACTIVE_LOW) and minterm result
//   hit_cnt             : only with DECODER_HIT_CNT_EN; saturating count of output
//                         handshakes with func = 1, cleared by cfg_we
module decoder_pipe_func
  import decoder_pkg::*;
#(
  parameter int unsigned  SEL_W      = 3,
  parameter bit           ACTIVE_LOW = 1'b1,
  parameter logic [63:0]  MASK_RST   = DEC_MASK_DEFAULT,
  localparam int unsigned OUT_W      = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e1_n,
  input  logic             e2_n,
  input  logic             e3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             cfg_we,
  input  logic [OUT_W-1:0] cfg_mask,
  output logic [OUT_W-1:0] mask_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
`ifdef DECODER_HIT_CNT_EN
  output logic [15:0]      hit_cnt,
`endif
  output logic             func
);

  localparam logic [OUT_W-1:0] YInactive = ACTIVE_LOW ? '1 : '0;
  localparam logic [OUT_W-1:0] MaskInit  = OUT_W'(MASK_RST);

  logic [OUT_W-1:0] dec_y;
  logic [OUT_W-1:0] s1_onehot;
  logic             s2_adv, s1_adv, accept;

  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_y_q, s1_y_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             func_q, func_d;
  logic [OUT_W-1:0] mask_reg_q, mask_reg_d;

  decoder_nx #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .e1_n (e1_n),
    .e2_n (e2_n),
    .e3   (e3),
    .sel  (sel),
    .y    (dec_y)
  );

  always_comb begin
    s2_adv = ~out_valid_q | out_ready;
    s1_adv = ~s1_valid_q | s2_adv;
    accept = in_valid & s1_adv;
    // Stage 1 holds the polarity-applied word; undo polarity to get the one-hot.
    s1_onehot = ACTIVE_LOW ? ~s1_y_q : s1_y_q;

    s1_valid_d = s1_adv ? accept : s1_valid_q;
    s1_y_d     = accept ? dec_y : s1_y_q;

    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    y_d         = y_q;
    func_d      = func_q;
    if (s2_adv && s1_valid_q) begin
      y_d    = s1_y_q;
      // Uses the mask value before any same-edge cfg_we write.
      func_d = |(s1_onehot & mask_reg_q);
    end

    mask_reg_d = cfg_we ? cfg_mask : mask_reg_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_y_q      <= YInactive;
      out_valid_q <= 1'b0;
      y_q         <= YInactive;
      func_q      <= 1'b0;
      mask_reg_q  <= MaskInit;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      func_q      <= func_d;
      mask_reg_q  <= mask_reg_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign func      = func_q;
  assign mask_q    = mask_reg_q;

`ifdef DECODER_HIT_CNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cfg_we) begin
      hit_cnt_d = '0;
    end else if (out_valid_q && out_ready && func_q && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_pipe_func.sv
// Bench for decoder_pipe_func: queue-based occupancy model checked every cycle,
// plus literal expectations for the directed scenarios and a SEL_W=4 active-high instance.
module tb_decoder_pipe_func;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, e1_n, e2_n, e3, in_valid, cfg_we, out_ready;
  logic [2:0] sel;
  logic [7:0] cfg_mask;
  logic       in_ready, out_valid, func;
  logic [7:0] mask_q, y;
`ifdef DECODER_HIT_CNT_EN
  logic [15:0] hit_cnt, hit_cnt4;
`endif

  logic        in_valid4, cfg_we4, out_ready4, in_ready4, out_valid4, func4;
  logic [3:0]  sel4;
  logic [15:0] cfg_mask4, mask_q4, y4;

  decoder_pipe_func #(.SEL_W(3), .ACTIVE_LOW(1'b1), .MASK_RST(64'hCA)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e1_n      (e1_n),
    .e2_n      (e2_n),
    .e3        (e3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .mask_q    (mask_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef DECODER_HIT_CNT_EN
    .hit_cnt   (hit_cnt),
`endif
    .func      (func)
  );

  decoder_pipe_func #(.SEL_W(4), .ACTIVE_LOW(1'b0), .MASK_RST(64'hCA)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .e1_n      (1'b0),
    .e2_n      (1'b0),
    .e3        (1'b1),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .sel       (sel4),
    .cfg_we    (cfg_we4),
    .cfg_mask  (cfg_mask4),
    .mask_q    (mask_q4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .y         (y4),
`ifdef DECODER_HIT_CNT_EN
    .hit_cnt   (hit_cnt4),
`endif
    .func      (func4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: items in flight, oldest first; the front one is in the output stage
  // when m_out_full is set. func is fixed when an item enters the output stage.
  typedef struct packed {
    logic [7:0] oh;
    logic       f;
  } item_t;

  item_t       mq[$];
  bit          m_out_full = 1'b0;
  logic [7:0]  m_mask     = 8'hCA;
  int unsigned m_hits     = 0;
  bit          started    = 1'b0;

  // DUT results seen at each output handshake, for the directed literal checks.
  logic [7:0]  log_y[$];
  logic        log_f[$];

  always @(posedge clk) if (!rst_n) started <= 1'b1;

  always @(negedge clk) begin
    bit         s1_occ, exp_ready, fire, adv2;
    item_t      t;
    logic [7:0] ey;
    s1_occ    = (mq.size() > (m_out_full ? 1 : 0));
    exp_ready = !(s1_occ && m_out_full && !out_ready);
    if (started) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_out_full));
      chk("mask_q", 64'(mask_q), 64'(m_mask));
      if (m_out_full) begin
        ey = ~mq[0].oh;
        chk("y", 64'(y), 64'(ey));
        chk("func", 64'(func), 64'(mq[0].f));
      end
`ifdef DECODER_HIT_CNT_EN
      chk("hit_cnt", 64'(hit_cnt), 64'(m_hits));
`endif
      if (out_valid && out_ready) begin
        log_y.push_back(y);
        log_f.push_back(func);
      end
    end
    if (!rst_n) begin
      mq.delete();
      m_out_full = 1'b0;
      m_mask     = 8'hCA;
      m_hits     = 0;
    end else begin
      fire = m_out_full && out_ready;
      adv2 = !m_out_full || out_ready;
      if (fire) begin
        t = mq.pop_front();
        if (t.f && m_hits < 32'hFFFF) m_hits++;
      end
      if (adv2) begin
        if (s1_occ) begin
          t       = mq[0];
          t.f     = |(t.oh & m_mask);
          mq[0]   = t;
          m_out_full = 1'b1;
        end else begin
          m_out_full = 1'b0;
        end
      end
      if (in_valid && exp_ready) begin
        t.oh = (e3 && !e1_n && !e2_n) ? (8'b1 << sel) : 8'h00;
        t.f  = 1'b0;
        mq.push_back(t);
      end
      if (cfg_we) begin
        m_mask = cfg_mask;
        m_hits = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int         base;
    logic [7:0] lit, ftab;
    bit         seen;
    rst_n = 1'b0; e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1;
    in_valid = 1'b0; sel = '0; cfg_we = 1'b0; cfg_mask = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; sel4 = '0; cfg_we4 = 1'b0; cfg_mask4 = '0; out_ready4 = 1'b1;
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'hFF);
    chk("rst_func", 64'(func), 64'd0);
    chk("rst_mask", 64'(mask_q), 64'hCA);

    // Sweep: sel 0..7 back to back.
    base = log_y.size();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; sel = 3'(i);
    end
    step(1); in_valid = 1'b0;
    step(4);
    chk("sweep_count", 64'(log_y.size() - base), 64'd8);
    ftab = 8'b1100_1010;  // func per sel: 1,3,6,7 set
    for (int i = 0; i < 8 && base + i < log_y.size(); i++) begin
      lit = ~(8'b1 << i);
      chk("sweep_y", 64'(log_y[base+i]), 64'(lit));
      chk("sweep_func", 64'(log_f[base+i]), 64'(ftab[i]));
    end

    // Disabled enables still produce a transaction.
    base = log_y.size();
    sel = 3'd5; in_valid = 1'b1;
    e3 = 1'b0; step(1);
    e3 = 1'b1; e1_n = 1'b1; step(1);
    e1_n = 1'b0; e2_n = 1'b1; step(1);
    e2_n = 1'b0; in_valid = 1'b0;
    step(4);
    chk("dis_count", 64'(log_y.size() - base), 64'd3);
    for (int i = 0; i < 3 && base + i < log_y.size(); i++) begin
      chk("dis_y", 64'(log_y[base+i]), 64'hFF);
      chk("dis_func", 64'(log_f[base+i]), 64'd0);
    end

    // Stall: two captured, then in_ready low.
    base = log_y.size();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 3'(2 + i);
      step(1);
    end
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    lit = ~8'b0000_0100;
    chk("stall_y_hold", 64'(y), 64'(lit));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    step(4);
    chk("stall_count", 64'(log_y.size() - base), 64'd2);
    if (log_y.size() - base == 2) begin
      lit = ~8'b0000_0100;
      chk("stall_first", 64'(log_y[base]), 64'(lit));
      lit = ~8'b0000_1000;
      chk("stall_second", 64'(log_y[base+1]), 64'(lit));
    end

    // Mask write on the same edge sel=0 moves into stage 2.
    base = log_y.size();
    in_valid = 1'b1; sel = 3'd0; step(1);
    in_valid = 1'b0; cfg_we = 1'b1; cfg_mask = 8'h01; step(1);
    cfg_we = 1'b0; in_valid = 1'b1; sel = 3'd0; step(1);
    in_valid = 1'b0; step(4);
    chk("mask_count", 64'(log_y.size() - base), 64'd2);
    if (log_y.size() - base == 2) begin
      chk("mask_old_func", 64'(log_f[base]), 64'd0);
      chk("mask_new_func", 64'(log_f[base+1]), 64'd1);
    end
    chk("mask_readback", 64'(mask_q), 64'h01);

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1; step(2);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_y", 64'(y), 64'hFF);
    chk("mrst_func", 64'(func), 64'd0);
    chk("mrst_mask", 64'(mask_q), 64'hCA);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      e1_n      = ($urandom_range(0, 7) == 0);
      e2_n      = ($urandom_range(0, 7) == 0);
      e3        = ($urandom_range(0, 7) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_mask  = 8'($urandom_range(0, 255));
      rst_n     = ($urandom_range(0, 63) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    e1_n = 1'b0; e2_n = 1'b0; e3 = 1'b1;
    step(4);

    // SEL_W=4 active-high instance.
    sel4 = 4'hF; in_valid4 = 1'b1; step(1);
    sel4 = 4'h1; step(1);
    in_valid4 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid4) seen = 1'b1;
    end
    chk("w4_seen", 64'(seen), 64'd1);
    chk("w4_y_f", 64'(y4), 64'h8000);
    chk("w4_func_f", 64'(func4), 64'd0);
    chk("w4_mask", 64'(mask_q4), 64'h00CA);
    @(negedge clk);
    chk("w4_y_1", 64'(y4), 64'h0002);
    chk("w4_func_1", 64'(func4), 64'd1);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_pipe_func.md
Name: decoder_pipe_func

Overview:
Parametrised, pipelined successor to the 3-to-8 active-low decoder with fixed sum-of-minterms output.
- Decodes a SEL_W-bit select into a 2^SEL_W one-hot word under a three-line enable (e1_n, e2_n, e3).
- Evaluates a runtime-programmable minterm function over the decoded word.
- Valid/ready streaming in and out; sits between select-generating control logic and downstream consumers.

Parameters:
SEL_W, 3, select width; decoded width OUT_W = 2**SEL_W (localparam, 1 <= SEL_W <= 6).
ACTIVE_LOW, 1, 1: y outputs active-low (inactive = all ones); 0: active-high (inactive = all zeros).
MASK_RST, 'hCA, reset value of minterm mask, truncated/zero-extended to OUT_W (default selects minterms 1,3,6,7).

Ports:
clk  in  1  clock.
rst_n  in  1  reset; synchronous, active-low.
e1_n  in  1  enable, active-low.
e2_n  in  1  enable, active-low.
e3  in  1  enable, active-high.
in_valid  in  1  sel/enables valid.
in_ready  out  1  block can accept.
sel  in  SEL_W  select; sel[SEL_W-1] is MSB (old A2).
cfg_we  in  1  mask write strobe.
cfg_mask  in  OUT_W  new minterm mask.
mask_q  out  OUT_W  current mask readback.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
y  out  OUT_W  decoded word, polarity per ACTIVE_LOW.
func  out  1  |(onehot & mask), always active-high.

Behaviour:
- Reset is the only synchronous-reset condition; everything is sampled on posedge clk.
- State after reset (rst_n low at an edge):
  - s1_valid = 0, out_valid = 0.
  - y = inactive (all ones if ACTIVE_LOW, else all zeros).
  - func = 0.
  - mask_q = MASK_RST.
- Reset mid-stream discards both stages with no partial output.
- Pipeline is 2 stages, latency 2 cycles from accept to out_valid with no stalls.
  - Stage 1 registers onehot = en ? (1 << sel) : 0, where en = e3 & ~e1_n & ~e2_n.
  - Stage 2 registers y (polarity-applied onehot) and func = |(onehot & mask_q).
- Handshake:
  - Accept when in_valid & in_ready.
  - Stage 2 advances when ~out_valid | out_ready.
  - Stage 1 advances when ~s1_valid | stage-2 advance.
  - in_ready = ~s1_valid | stage-2 advance (combinational from out_ready).
  - Full throughput: 1 transaction/cycle when out_ready is held high.
- Stall: out_valid high and out_ready low holds y and func stable. Stage 1 holds if full; in_ready drops when both stages are full.
- Disabled enables are still a valid transaction: y = inactive, func = 0.
- Mask:
  - cfg_we loads cfg_mask into mask_q at the edge; cfg_we is accepted regardless of handshake state.
  - The mask is applied when data moves stage 1 -> 2.
  - If cfg_we is asserted on the same edge as a stage-1 -> stage-2 transfer, the OLD mask is used; the new mask affects transfers from the next edge on.
  - Data already held in stage 2 is never re-evaluated.
- sel has no illegal values; all 2^SEL_W codes decode.
- Ignore in_valid during reset.

Optional Feature:
DECODER_HIT_CNT_EN
- Defined: adds output hit_cnt[15:0], which increments on each output handshake (out_valid & out_ready) with func = 1.
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Cleared by cfg_we (clear takes priority over a same-cycle increment).
- Undefined: port and logic are absent; all other behaviour is unchanged.

Decomposition:
- Package decoder_pkg:
  - SEL_W_MAX = 6.
  - Default mask constant DEC_MASK_DEFAULT = 'hCA.
  - Function onehot_dec(sel, en), returning a one-hot word.
- Sub-module decoder_nx: purely combinational SEL_W-to-OUT_W decoder with e1_n/e2_n/e3 enables and ACTIVE_LOW polarity. It is instantiated once before the stage-1 register.
- Top holds the handshake, mask register and optional counter.

Test Plan:
1. Defaults (SEL_W=3, ACTIVE_LOW=1), enables asserted, out_ready=1, sel sweep 0..7 back-to-back.
   -> Two cycles after each accept: y = ~(8'b1 << sel).
   -> func = 1 exactly for sel 1,3,6,7.
   -> One result per cycle.
2. sel=5 with e3=0, then e1_n=1, then e2_n=1.
   -> y = 8'hFF, func = 0, out_valid still asserted for each.
3. out_ready=0 for 4 cycles while in_valid=1.
   -> Two transactions are captured, then in_ready = 0.
   -> y/func stay stable.
   -> On release, results emerge in order with no loss or duplication.
4. cfg_we with cfg_mask=8'h01 on the same edge sel=0 transfers stage 1 -> 2.
   -> That result gives func = 0 (old mask 'hCA).
   -> The next sel=0 gives func = 1.
   -> mask_q = 8'h01.
5. rst_n low for 1 cycle with both stages full.
   -> Next cycle: out_valid = 0, y = 8'hFF, func = 0, mask_q = 8'hCA.
6. SEL_W=4, ACTIVE_LOW=0, sel=4'hF.
   -> y = 16'h8000, func = 0 (MASK_RST zero-extended gives 16'h00CA).
   -> With DECODER_HIT_CNT_EN: 3 hits read 3; after 65,536+ hits hit_cnt holds 16'hFFFF.
